busmux_n: RTL and testbench
===========================

Name: busmux_n

Overview:
- Parametrised successor to the fixed busmux: connects the datapath data port to N_SLV memory-mapped slaves, each selected by a base/mask address window.
- Adds a per-slave ready handshake, automatic CPU stall generation, a registered read-data return, a timeout watchdog, and a bus-error pulse for decode misses and timeouts.
- Sits between datapath and the memory/peripheral slaves inside the CPU top.

Parameters:
- N_SLV, 4, number of slave ports (1..16).
- SLV_BASE, {32'h0000_0000, 32'h4000_0000, 32'hE000_0000, 32'hF000_0000}, packed array [N_SLV][32]; window base per slave.
- SLV_MASK, {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}, packed array [N_SLV][32]; slave k hits when (addr & MASK[k]) == BASE[k].
- TIMEOUT, 15, maximum BUSY cycles without ready before error; counter width is $clog2(TIMEOUT+1).
- ERR_DATA, 32'h0000_0000, value driven on cpu_data_in in the error cycle.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_address  in  32  byte address from datapath.
- cpu_data_out  in  32  write data from datapath.
- cpu_data_w  in  4  byte write strobes; 0 means a read.
- cpu_data_access  in  1  access request; held stable while cpu_stall=1.
- cpu_data_in  out  32  read data to datapath.
- cpu_stall  out  1  stalls the datapath.
- cpu_bus_err  out  1  one-cycle error pulse (routed to the exception/irq logic).
- slv_req  out  N_SLV  one-hot request, registered.
- slv_addr  out  32  latched address, shared by all slaves.
- slv_wdata  out  32  latched write data, shared.
- slv_we  out  4  latched byte strobes, shared.
- slv_rdata  in  N_SLV*32  read data, slave k at [32k+31:32k].
- slv_ready  in  N_SLV  slave completion; sampled only for the selected slave.

Behaviour:
- Reset values: state=IDLE; slv_req=0; slv_addr, slv_wdata, slv_we = 0; rdata_q=0; timeout counter=0; cpu_bus_err=0.
- Decode is combinational on cpu_address. On multiple hits, the lowest index wins. A miss is a decode error.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE, access with a hit on slave k:
  - latch k, address, data and strobes;
  - set slv_req[k]=1;
  - clear the counter;
  - go to BUSY.
- IDLE, access with a miss: go to ERR; no slv_req is issued.
- BUSY, slv_ready[k]=1:
  - rdata_q <= slv_rdata[k];
  - slv_req <= 0;
  - go to RESP.
- BUSY, no ready: counter increments. When counter==TIMEOUT-1 with still no ready: slv_req <= 0, go to ERR.
- Ready from non-selected slaves is ignored.
- RESP: cpu_data_in=rdata_q (also for writes, value don't-care); go to IDLE.
- ERR: cpu_bus_err=1 and cpu_data_in=ERR_DATA for exactly one cycle; go to IDLE.
- cpu_stall = (state==IDLE && cpu_data_access) || state==BUSY. Stall is low in RESP and ERR, so the CPU consumes the result that cycle.
- Minimum latency, access in cycle 0:
  - cycle 1: BUSY with req=1;
  - ready in cycle 1 gives RESP in cycle 2, stall low in cycle 2;
  - 2 stall cycles per access.
- Back-to-back: a new access can be accepted in the IDLE cycle after RESP or ERR. No pipelining.
- Reset asserted mid-transaction: all state clears immediately. slv_req and cpu_stall drop without waiting for clock, and no error is raised.
- A slave that asserts ready in the same cycle the timeout expires completes normally; ready has priority.

Decomposition:
- Package busmux_pkg holds:
  - state enum bus_state_t {IDLE, BUSY, RESP, ERR};
  - constant BUS_DW=32;
  - function decode(addr, base[], mask[]) returning {hit, idx}.
- Sub-module busmux_decode: purely combinational, parametrised on N_SLV/SLV_BASE/SLV_MASK, outputs hit and idx. The top holds the FSM, latches, counter and read mux.

Test Plan:
- Read slave 1, addr 0x4000_0010, ready on the first BUSY cycle with rdata 0xCAFE_F00D -> slv_req=4'b0010 for 1 cycle; stall high for 2 cycles; cpu_data_in=0xCAFE_F00D in RESP; bus_err=0.
- Byte write 0xE000_0003, data_w=4'b1000, data 0x1200_0000, ready after 3 cycles -> slv_we=4'b1000, slv_wdata=0x1200_0000 stable throughout BUSY; stall lasts 5 cycles.
- Access to 0x8000_0000 (no window) -> no slv_req; cpu_bus_err pulses 1 cycle after 1 stall cycle; cpu_data_in=ERR_DATA.
- Slave 2 never ready, TIMEOUT=15 -> req drops after 15 BUSY cycles; bus_err single pulse; next access accepted the following cycle.
- Overlapping windows (SLV_BASE[0]=SLV_BASE[3]=0, same mask), addr 0x0 -> only slv_req[0] asserts; ready from slave 3 is ignored.
- Assert reset in the 2nd BUSY cycle -> slv_req=0 and cpu_stall=0 asynchronously; after release, a read completes normally with no bus_err.

Source files
------------

// File: rtl/busmux_pkg.sv
// Shared types and the address-window decode function for the N-slave data bus mux.
package busmux_pkg;

  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_SW  = 4;
  localparam int unsigned MAX_SLV = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_res_t;

  typedef logic [MAX_SLV-1:0][BUS_DW-1:0] win_tbl_t;

  // First matching window wins, so lower slave indices shadow higher ones.
  function automatic dec_res_t decode(input logic [BUS_DW-1:0] addr,
                                      input win_tbl_t          base,
                                      input win_tbl_t          mask,
                                      input int unsigned       n_slv);
    dec_res_t res;
    res = '0;
    for (int unsigned k = 0; k < MAX_SLV; k++) begin
      if (!res.hit && (k < n_slv) && ((addr & mask[k]) == base[k])) begin
        res.hit = 1'b1;
        res.idx = IDX_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/busmux_decode.sv
// Combinational base/mask address decoder: reports whether any window hits and which one.
module busmux_decode
  import busmux_pkg::*;
#(
  parameter int unsigned                    N_SLV    = 4,
  parameter logic [N_SLV-1:0][BUS_DW-1:0]   SLV_BASE = {32'hF000_0000, 32'hE000_0000,
                                                        32'h4000_0000, 32'h0000_0000},
  parameter logic [N_SLV-1:0][BUS_DW-1:0]   SLV_MASK = {32'hF000_0000, 32'hF000_0000,
                                                        32'hF000_0000, 32'hF000_0000}
) (
  input  logic [BUS_DW-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  win_tbl_t base_pad;
  win_tbl_t mask_pad;
  dec_res_t dec;

  // Widen the parameter tables to the fixed size the package function expects.
  for (genvar k = 0; k < MAX_SLV; k++) begin : g_pad
    if (k < N_SLV) begin : g_use
      assign base_pad[k] = SLV_BASE[k];
      assign mask_pad[k] = SLV_MASK[k];
    end else begin : g_nil
      assign base_pad[k] = '0;
      assign mask_pad[k] = '0;
    end
  end

  assign dec   = decode(addr_i, base_pad, mask_pad, N_SLV);
  assign hit_o = dec.hit;
  assign idx_o = dec.idx;

endmodule

// File: rtl/busmux_n.sv
// Data-port bus mux for N memory-mapped slaves: decode, request/ready handshake,
// CPU stall, registered read return, timeout watchdog and bus-error pulse.
module busmux_n
  import busmux_pkg::*;
#(
  parameter int unsigned                    N_SLV    = 4,
  parameter logic [N_SLV-1:0][BUS_DW-1:0]   SLV_BASE = {32'hF000_0000, 32'hE000_0000,
                                                        32'h4000_0000, 32'h0000_0000},
  parameter logic [N_SLV-1:0][BUS_DW-1:0]   SLV_MASK = {32'hF000_0000, 32'hF000_0000,
                                                        32'hF000_0000, 32'hF000_0000},
  parameter int unsigned                    TIMEOUT  = 15,
  parameter logic [BUS_DW-1:0]              ERR_DATA = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BUS_DW-1:0]         cpu_address,
  input  logic [BUS_DW-1:0]         cpu_data_out,
  input  logic [BUS_SW-1:0]         cpu_data_w,
  input  logic                      cpu_data_access,
  output logic [BUS_DW-1:0]         cpu_data_in,
  output logic                      cpu_stall,
  output logic                      cpu_bus_err,
  output logic [N_SLV-1:0]          slv_req,
  output logic [BUS_DW-1:0]         slv_addr,
  output logic [BUS_DW-1:0]         slv_wdata,
  output logic [BUS_SW-1:0]         slv_we,
  input  logic [N_SLV*BUS_DW-1:0]   slv_rdata,
  input  logic [N_SLV-1:0]          slv_ready
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t          state_q, state_d;
  logic [N_SLV-1:0]    req_q, req_d;
  logic [BUS_DW-1:0]   addr_q, addr_d;
  logic [BUS_DW-1:0]   wdata_q, wdata_d;
  logic [BUS_SW-1:0]   we_q, we_d;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [N_SLV-1:0]    dec_oh;
  logic                sel_ready;
  logic [BUS_DW-1:0]   sel_rdata;

  busmux_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (cpu_address),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    dec_oh = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      dec_oh[k] = (dec_idx == IDX_W'(k));
    end
  end

  // req_q stays one-hot on the selected slave for the whole BUSY phase,
  // so it doubles as the ready/read-data select.
  always_comb begin
    sel_ready = |(slv_ready & req_q);
    sel_rdata = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (req_q[k]) begin
        sel_rdata = sel_rdata | slv_rdata[k*BUS_DW +: BUS_DW];
      end
    end
  end

  // Next-state logic; ready is checked before the timeout so a late ready still completes.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_data_access) begin
          if (dec_hit) begin
            req_d   = dec_oh;
            addr_d  = cpu_address;
            wdata_d = cpu_data_out;
            we_d    = cpu_data_w;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          req_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall is gated by reset so a held access request cannot stall the CPU during reset.
  assign cpu_stall   = reset & (((state_q == IDLE) & cpu_data_access) | (state_q == BUSY));
  assign cpu_bus_err = (state_q == ERR);
  assign cpu_data_in = (state_q == ERR) ? ERR_DATA : rdata_q;
  assign slv_req     = req_q;
  assign slv_addr    = addr_q;
  assign slv_wdata   = wdata_q;
  assign slv_we      = we_q;

endmodule

// File: tb/tb_busmux_n.sv
// Randomised and directed bench for busmux_n against a transaction-level reference model.
module tb_busmux_n;

  localparam int unsigned N    = 4;
  localparam int          TMO  = 15;
  localparam logic [31:0] ERRD = 32'hBAD0_0BAD;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       cpu_address = '0;
  logic [31:0]       cpu_data_out = '0;
  logic [3:0]        cpu_data_w = '0;
  logic              cpu_data_access = 1'b0;
  logic [31:0]       cpu_data_in;
  logic              cpu_stall;
  logic              cpu_bus_err;
  logic [N-1:0]      slv_req;
  logic [31:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [3:0]        slv_we;
  logic [N*32-1:0]   slv_rdata = '0;
  logic [N-1:0]      slv_ready = '0;

  int checks = 0;
  int errors = 0;

  // Slaves 0 and 3 overlap at 0x0xxx_xxxx; 0x8/0x1/0xF regions decode to nothing.
  logic [31:0] m_base [N] = '{32'h0000_0000, 32'h4000_0000, 32'hE000_0000, 32'h0000_0000};
  logic [31:0] m_mask [N] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  busmux_n #(
    .N_SLV    (N),
    .SLV_BASE ({32'h0000_0000, 32'hE000_0000, 32'h4000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERRD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_data_out    (cpu_data_out),
    .cpu_data_w      (cpu_data_w),
    .cpu_data_access (cpu_data_access),
    .cpu_data_in     (cpu_data_in),
    .cpu_stall       (cpu_stall),
    .cpu_bus_err     (cpu_bus_err),
    .slv_req         (slv_req),
    .slv_addr        (slv_addr),
    .slv_wdata       (slv_wdata),
    .slv_we          (slv_we),
    .slv_rdata       (slv_rdata),
    .slv_ready       (slv_ready)
  );

  always #5 clock = ~clock;

  // Observations of the most recent transaction.
  int          o_stall, o_req_cyc, o_err_cnt, o_latch_bad;
  logic [N-1:0] o_req_or;
  logic [31:0] o_data;
  logic        o_err_resp, o_done;

  // Transaction reference: decode with lowest-index priority, then count cycles.
  function automatic void model(input logic [31:0] addr, input int lat,
                                output logic hit, output int idx, output int stall,
                                output int req_cyc, output logic err);
    hit = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      if (!hit && ((addr & m_mask[k]) == m_base[k])) begin
        hit = 1'b1;
        idx = k;
      end
    end
    if (!hit) begin
      stall = 1; req_cyc = 0; err = 1'b1;
    end else if (lat >= 0 && lat < TMO) begin
      stall = lat + 2; req_cyc = lat + 1; err = 1'b0;
    end else begin
      stall = TMO + 1; req_cyc = TMO; err = 1'b1;
    end
  endfunction

  // Drives one access; slave rdy_slv answers on BUSY cycle lat (-1: never), ghost answers every BUSY cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we,
                         input int lat, input int rdy_slv, input int ghost, input logic [31:0] rd);
    int busy;
    busy = 0;
    o_stall = 0; o_req_cyc = 0; o_err_cnt = 0; o_latch_bad = 0;
    o_req_or = '0; o_data = '0; o_err_resp = 1'b0; o_done = 1'b0;
    @(negedge clock);
    for (int k = 0; k < N; k++) slv_rdata[k*32 +: 32] = $urandom();
    slv_rdata[rdy_slv*32 +: 32] = rd;
    if (ghost >= 0) slv_rdata[ghost*32 +: 32] = ~rd;
    cpu_address = addr; cpu_data_out = wd; cpu_data_w = we; cpu_data_access = 1'b1;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (cpu_bus_err) o_err_cnt++;
      if (!cpu_stall) begin
        o_data = cpu_data_in;
        o_err_resp = cpu_bus_err;
        o_done = 1'b1;
        break;
      end
      o_stall++;
      slv_ready = '0;
      if (slv_req != '0) begin
        o_req_cyc++;
        o_req_or = o_req_or | slv_req;
        if (slv_addr !== addr || slv_wdata !== wd || slv_we !== we) o_latch_bad++;
        if (busy == lat) slv_ready[rdy_slv] = 1'b1;
        if (ghost >= 0) slv_ready[ghost] = 1'b1;
        busy++;
      end
      @(negedge clock);
    end
    cpu_data_access = 1'b0;
    slv_ready = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (slv_req !== '0) begin errors++; $display("FAIL reset_req: got %b exp 0", slv_req); end
    checks++; if (slv_addr !== '0 || slv_wdata !== '0 || slv_we !== '0) begin
      errors++; $display("FAIL reset_latch: got %h/%h/%b exp 0", slv_addr, slv_wdata, slv_we); end
    checks++; if (cpu_bus_err !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got err=%b stall=%b exp 0/0", cpu_bus_err, cpu_stall); end
    checks++; if (cpu_data_in !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", cpu_data_in); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read_slave1();
    run_txn(32'h4000_0010, 32'h0, 4'b0000, 0, 1, -1, 32'hCAFE_F00D);
    checks++; if (o_req_or !== 4'b0010 || o_req_cyc !== 1) begin
      errors++; $display("FAIL rd1_req: got %b x%0d exp 0010 x1", o_req_or, o_req_cyc); end
    checks++; if (o_stall !== 2) begin errors++; $display("FAIL rd1_stall: got %0d exp 2", o_stall); end
    checks++; if (o_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd1_data: got %h exp cafef00d", o_data); end
    checks++; if (o_err_cnt !== 0) begin errors++; $display("FAIL rd1_err: got %0d exp 0", o_err_cnt); end
  endtask

  task automatic test_byte_write();
    run_txn(32'hE000_0003, 32'h1200_0000, 4'b1000, 3, 2, -1, $urandom());
    checks++; if (o_latch_bad !== 0) begin errors++; $display("FAIL wr_latch: got %0d bad cycles exp 0", o_latch_bad); end
    checks++; if (o_stall !== 5) begin errors++; $display("FAIL wr_stall: got %0d exp 5", o_stall); end
    checks++; if (o_req_or !== 4'b0100) begin errors++; $display("FAIL wr_req: got %b exp 0100", o_req_or); end
    checks++; if (slv_we !== 4'b1000 || slv_wdata !== 32'h1200_0000) begin
      errors++; $display("FAIL wr_hold: got %b/%h exp 1000/12000000", slv_we, slv_wdata); end
  endtask

  task automatic test_decode_miss();
    run_txn(32'h8000_0000, 32'h5555_AAAA, 4'b0000, 0, 0, -1, 32'h1111_2222);
    checks++; if (o_req_or !== '0) begin errors++; $display("FAIL miss_req: got %b exp 0000", o_req_or); end
    checks++; if (o_stall !== 1) begin errors++; $display("FAIL miss_stall: got %0d exp 1", o_stall); end
    checks++; if (o_err_resp !== 1'b1 || o_err_cnt !== 1) begin
      errors++; $display("FAIL miss_err: got resp=%b cnt=%0d exp 1/1", o_err_resp, o_err_cnt); end
    checks++; if (o_data !== ERRD) begin errors++; $display("FAIL miss_data: got %h exp %h", o_data, ERRD); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    run_txn(32'hE000_0100, 32'h0, 4'b0000, -1, 2, -1, 32'h0);
    checks++; if (o_req_cyc !== TMO) begin errors++; $display("FAIL tmo_req: got %0d exp %0d", o_req_cyc, TMO); end
    checks++; if (o_stall !== TMO + 1) begin errors++; $display("FAIL tmo_stall: got %0d exp %0d", o_stall, TMO + 1); end
    checks++; if (o_err_cnt !== 1 || o_err_resp !== 1'b1) begin
      errors++; $display("FAIL tmo_err: got cnt=%0d resp=%b exp 1/1", o_err_cnt, o_err_resp); end
    checks++; if (o_data !== ERRD) begin errors++; $display("FAIL tmo_data: got %h exp %h", o_data, ERRD); end
    rd = $urandom();
    run_txn(32'h4000_0000, 32'h0, 4'b0000, 1, 1, -1, rd);
    checks++; if (o_stall !== 3 || o_data !== rd || o_err_cnt !== 0) begin
      errors++; $display("FAIL tmo_next: got stall=%0d data=%h err=%0d exp 3/%h/0", o_stall, o_data, o_err_cnt, rd); end
  endtask

  task automatic test_ready_at_expiry();
    logic [31:0] rd;
    rd = $urandom();
    run_txn(32'hE000_0200, 32'h0, 4'b0000, TMO - 1, 2, -1, rd);
    checks++; if (o_stall !== TMO + 1 || o_data !== rd || o_err_cnt !== 0) begin
      errors++; $display("FAIL late_rdy: got stall=%0d data=%h err=%0d exp %0d/%h/0", o_stall, o_data, o_err_cnt, TMO + 1, rd); end
  endtask

  task automatic test_overlap();
    logic [31:0] rd;
    rd = $urandom();
    run_txn(32'h0000_0000, 32'h0, 4'b0000, 2, 0, 3, rd);
    checks++; if (o_req_or !== 4'b0001) begin errors++; $display("FAIL ovl_req: got %b exp 0001", o_req_or); end
    checks++; if (o_stall !== 4 || o_data !== rd) begin
      errors++; $display("FAIL ovl_ghost: got stall=%0d data=%h exp 4/%h", o_stall, o_data, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    @(negedge clock);
    cpu_address = 32'h4000_0020; cpu_data_w = 4'b0000; cpu_data_access = 1'b1; slv_ready = '0;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++; if (slv_req !== 4'b0010 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got req=%b stall=%b exp 0010/1", slv_req, cpu_stall); end
    #1 reset = 1'b0;
    #1;
    checks++; if (slv_req !== '0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got req=%b stall=%b exp 0000/0", slv_req, cpu_stall); end
    checks++; if (cpu_bus_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b exp 0", cpu_bus_err); end
    @(negedge clock);
    cpu_data_access = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rd = $urandom();
    run_txn(32'h4000_0024, 32'h0, 4'b0000, 0, 1, -1, rd);
    checks++; if (o_stall !== 2 || o_data !== rd || o_err_cnt !== 0) begin
      errors++; $display("FAIL rstmid_after: got stall=%0d data=%h err=%0d exp 2/%h/0", o_stall, o_data, o_err_cnt, rd); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd;
    logic [3:0]  we;
    logic [31:0] hi [6] = '{32'h0000_0000, 32'h4000_0000, 32'hE000_0000,
                            32'hF000_0000, 32'h8000_0000, 32'h1000_0000};
    logic        e_hit, e_err;
    int          e_idx, e_stall, e_req_cyc, lat, ghost;
    for (int t = 0; t < 40; t++) begin
      addr = hi[$urandom_range(0, 5)] | ($urandom() & 32'h0FFF_FFFF);
      wd   = $urandom();
      we   = 4'($urandom());
      rd   = $urandom();
      lat  = $urandom_range(0, 17);
      model(addr, lat, e_hit, e_idx, e_stall, e_req_cyc, e_err);
      ghost = ($urandom_range(0, 1) == 1) ? (e_idx + 1) % N : -1;
      run_txn(addr, wd, we, lat, e_idx, ghost, rd);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: got %b exp 1", t, o_done); end
      checks++; if (o_stall !== e_stall) begin errors++; $display("FAIL rnd%0d_stall: got %0d exp %0d", t, o_stall, e_stall); end
      checks++; if (o_req_cyc !== e_req_cyc) begin errors++; $display("FAIL rnd%0d_reqcyc: got %0d exp %0d", t, o_req_cyc, e_req_cyc); end
      checks++; if (o_req_or !== (e_hit ? N'(1 << e_idx) : N'(0))) begin
        errors++; $display("FAIL rnd%0d_req: got %b hit=%b idx=%0d", t, o_req_or, e_hit, e_idx); end
      checks++; if (o_data !== (e_err ? ERRD : rd)) begin
        errors++; $display("FAIL rnd%0d_data: got %h exp %h", t, o_data, e_err ? ERRD : rd); end
      checks++; if (o_err_cnt !== (e_err ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_err: got %0d exp %0d", t, o_err_cnt, e_err ? 1 : 0); end
      checks++; if (o_latch_bad !== 0) begin errors++; $display("FAIL rnd%0d_latch: got %0d exp 0", t, o_latch_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_read_slave1();
    test_byte_write();
    test_decode_miss();
    test_timeout();
    test_ready_at_expiry();
    test_overlap();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
